sg_req_scheduler: RTL
=====================

# sg_req_scheduler

Sequences one scatter-gather transfer: pulls (address, length) elements from the scatter-gather element reader and issues read/write requests of bounded size to the TX request engine. Each element is split into chunks limited by a maximum request size, the remaining transfer length and, optionally, 4 KB address boundaries. It sits between the per-channel SG list reader and the channel's TX request port, and reports progress to the channel controller.

## Interface

- C_MAX_REQ_WORDS, 32, max words per request; power of 2, 1..512
- C_REQ_LEN_W, $clog2(C_MAX_REQ_WORDS)+1, width of REQ_LEN
- CLK  in  1  clock
- RST_N  in  1  reset; one clock, reset is asynchronous and active-low
- XFER_START  in  1  single-cycle pulse, start transfer (honoured only in IDLE)
- XFER_LEN  in  32  total transfer length in words, sampled with XFER_START
- XFER_ABORT  in  1  level/pulse, abandon the transfer
- SG_VALID  in  1  SG element valid
- SG_EMPTY  in  1  SG element source empty (status only; not used for control)
- SG_REN  out  1  SG element consume strobe
- SG_ADDR  in  64  element byte address, dword aligned
- SG_LEN  in  32  element length in words
- REQ  out  1  request valid
- REQ_ACK  in  1  request accepted
- REQ_ADDR  out  64  request byte address
- REQ_LEN  out  C_REQ_LEN_W  request length in words, 1..C_MAX_REQ_WORDS
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  single-cycle pulse, transfer fully requested
- WORDS_REQ  out  32  words acknowledged in current/last transfer

## Operation

- States: IDLE, WAIT_SG, CALC, ISSUE, FIN.
- IDLE: on XFER_START, clear WORDS_REQ and latch xfer_rem = XFER_LEN. Go to WAIT_SG, or to FIN if XFER_LEN == 0.
- WAIT_SG:
  - SG_REN = SG_VALID (combinational, this state only).
  - On SG_VALID, latch cur_addr = SG_ADDR and elem_rem = SG_LEN.
  - SG_LEN == 0: element is consumed and skipped; stay in WAIT_SG. Otherwise go to CALC.
- CALC: chunk = min(elem_rem, xfer_rem, C_MAX_REQ_WORDS[, 1024 - cur_addr[11:2]]). Register REQ_ADDR = cur_addr and REQ_LEN = chunk; go to ISSUE.
- ISSUE:
  - REQ = 1; REQ_ADDR and REQ_LEN are held stable until REQ_ACK.
  - On REQ_ACK: cur_addr += chunk<<2, elem_rem -= chunk, xfer_rem -= chunk, WORDS_REQ += chunk.
  - Next state: xfer_rem reaching 0 → FIN; else elem_rem reaching 0 → WAIT_SG; else → CALC.
- FIN: DONE = 1 for one cycle, then IDLE.
- An element longer than the remaining transfer is consumed; its excess words are discarded and never requested.
- XFER_ABORT in any non-IDLE state: next state is IDLE and no DONE pulse is produced.
  - Abort together with REQ_ACK in ISSUE: the acknowledgement is still accounted in WORDS_REQ.
  - Abort together with SG_VALID in WAIT_SG: SG_REN still pulses and the element is dropped.
- XFER_START outside IDLE is ignored.
- Arithmetic: 64-bit address adds wrap modulo 2^64; counters are 32-bit unsigned; min() is unsigned.

## Timing

- Reset values: REQ=0, SG_REN=0, BUSY=0, DONE=0, WORDS_REQ=0, REQ_ADDR=0, REQ_LEN=0; state = IDLE. Reset acts asynchronously mid-transfer with no partial outputs.
- XFER_START at cycle 0 → WAIT_SG at cycle 1. With SG_VALID at cycle 1, REQ is first asserted at cycle 3.
- Minimum spacing between requests is 2 cycles (CALC + ISSUE); REQ_ACK on the first REQ cycle is legal.
- DONE is asserted the cycle after the final REQ_ACK. BUSY falls the cycle after DONE.
- REQ_ADDR and REQ_LEN are registered outputs; SG_REN is combinational from SG_VALID and the state.

## Configuration

- SG_4KB_SPLIT_EN defined: chunks never cross a 4 KB address boundary (the fourth min() term is present).
- SG_4KB_SPLIT_EN undefined: only the element length, remaining transfer length and C_MAX_REQ_WORDS limit a chunk.

## Structure

- Package sg_sched_pkg holds:
  - the state enum;
  - C_4KB_WORDS = 1024;
  - a min3/min4 unsigned function.
- Sub-module sg_req_len_calc: combinational chunk-size computation, including the macro-guarded boundary term, instantiated by CALC logic.

## Test plan

- C_MAX_REQ_WORDS=32, XFER_LEN=100, one element (0x1000, 100) → REQs 0x1000/32, 0x1080/32, 0x1100/32, 0x1180/4; DONE once; WORDS_REQ=100.
- Element (0x1FF0, 16), XFER_LEN=16 → with SG_4KB_SPLIT_EN: 0x1FF0/4 then 0x2000/12; without: 0x1FF0/16.
- XFER_LEN=10, element (0x0, 64) → single REQ 0x0/10; SG_REN pulses once; DONE.
- Elements (0x100, 0), (0x200, 8), XFER_LEN=8 → SG_REN pulses twice; single REQ 0x200/8.
- XFER_ABORT while REQ is held without ack → REQ low next cycle; BUSY=0; no DONE; WORDS_REQ unchanged. Repeat with REQ_ACK in the same cycle → WORDS_REQ includes that chunk.
- RST_N low mid-ISSUE, asynchronous to CLK → all outputs at reset values immediately; a new XFER_START after release runs normally.

Source files
------------

// File: rtl/sg_sched_pkg.sv
// Shared types and helpers for the scatter-gather request scheduler.
// Used by sg_req_scheduler and sg_req_len_calc.
package sg_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SG,
        ST_CALC,
        ST_ISSUE,
        ST_FIN
    } state_t;

    // Words in one 4 KB page (dword granularity)
    localparam logic [31:0] C_4KB_WORDS = 32'd1024;

    function automatic logic [31:0] min3(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] c);
        logic [31:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [31:0] min4(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] c,
                                         input logic [31:0] d);
        logic [31:0] m;
        m = min3(a, b, c);
        return (m < d) ? m : d;
    endfunction

endpackage

// File: rtl/sg_req_len_calc.sv
// Combinational chunk-size computation for one request.
// Macro SG_4KB_SPLIT_EN adds the "words left in this 4 KB page" limit.
module sg_req_len_calc
    import sg_sched_pkg::*;
#(
    parameter int C_MAX_REQ_WORDS = 32,
    parameter int C_REQ_LEN_W     = $clog2(C_MAX_REQ_WORDS) + 1
) (
    input  logic [31:0]            elem_rem,
    input  logic [31:0]            xfer_rem,
`ifdef SG_4KB_SPLIT_EN
    input  logic [9:0]             page_off,
`endif
    output logic [C_REQ_LEN_W-1:0] chunk
);

    localparam logic [31:0] MAX_WORDS = 32'(C_MAX_REQ_WORDS);

    logic [31:0] chunk_wide;

`ifdef SG_4KB_SPLIT_EN
    logic [31:0] to_boundary;

    // page_off is the dword index inside the page, so this is 1..1024
    assign to_boundary = C_4KB_WORDS - {22'd0, page_off};
    assign chunk_wide  = min4(elem_rem, xfer_rem, MAX_WORDS, to_boundary);
`else
    assign chunk_wide  = min3(elem_rem, xfer_rem, MAX_WORDS);
`endif

    // chunk_wide never exceeds MAX_WORDS; the compare narrows it without dropping bits
    assign chunk = (chunk_wide >= MAX_WORDS) ? C_REQ_LEN_W'(C_MAX_REQ_WORDS)
                                             : chunk_wide[C_REQ_LEN_W-1:0];

endmodule

// File: rtl/sg_req_scheduler.sv
// Splits one scatter-gather transfer into bounded read/write requests.
// Optional macro SG_4KB_SPLIT_EN keeps every request inside one 4 KB page.
module sg_req_scheduler
    import sg_sched_pkg::*;
#(
    parameter int C_MAX_REQ_WORDS = 32,
    parameter int C_REQ_LEN_W     = $clog2(C_MAX_REQ_WORDS) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   xfer_start,
    input  logic [31:0]            xfer_len,
    input  logic                   xfer_abort,
    input  logic                   sg_valid,
    input  logic                   sg_empty,
    output logic                   sg_ren,
    input  logic [63:0]            sg_addr,
    input  logic [31:0]            sg_len,
    output logic                   req,
    input  logic                   req_ack,
    output logic [63:0]            req_addr,
    output logic [C_REQ_LEN_W-1:0] req_len,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            words_req
);

    state_t                   state;
    logic [31:0]              xfer_rem;
    logic [31:0]              elem_rem;
    logic [63:0]              cur_addr;
    logic [C_REQ_LEN_W-1:0]   chunk;
    logic [31:0]              req_words;
    logic                     unused_sg_empty;

    assign unused_sg_empty = sg_empty;
    assign req_words       = 32'(req_len);

    sg_req_len_calc #(
        .C_MAX_REQ_WORDS (C_MAX_REQ_WORDS),
        .C_REQ_LEN_W     (C_REQ_LEN_W)
    ) u_len_calc (
        .elem_rem (elem_rem),
        .xfer_rem (xfer_rem),
`ifdef SG_4KB_SPLIT_EN
        .page_off (cur_addr[11:2]),
`endif
        .chunk    (chunk)
    );

    // NOTE: sg_ren must be combinational so the element is consumed in the same cycle it is seen.
    assign sg_ren = (state == ST_WAIT_SG) && sg_valid;

    // Status outputs are pure decodes of the state register, so they change only on clk.
    assign req  = (state == ST_ISSUE);
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIN);

    // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            xfer_rem  <= '0;
            elem_rem  <= '0;
            cur_addr  <= '0;
            req_addr  <= '0;
            req_len   <= '0;
            words_req <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (xfer_start) begin
                        words_req <= '0;
                        xfer_rem  <= xfer_len;
                        state     <= (xfer_len == 32'd0) ? ST_FIN : ST_WAIT_SG;
                    end
                end

                ST_WAIT_SG: begin
                    if (sg_valid) begin
                        cur_addr <= sg_addr;
                        elem_rem <= sg_len;
                    end
                    if (xfer_abort)
                        state <= ST_IDLE;
                    else if (sg_valid && (sg_len != 32'd0))
                        state <= ST_CALC;
                end

                ST_CALC: begin
                    req_addr <= cur_addr;
                    req_len  <= chunk;
                    state    <= xfer_abort ? ST_IDLE : ST_ISSUE;
                end

                ST_ISSUE: begin
                    // An ack is accounted even when abort arrives in the same cycle
                    if (req_ack) begin
                        cur_addr  <= cur_addr + (64'(req_words) << 2);
                        elem_rem  <= elem_rem - req_words;
                        xfer_rem  <= xfer_rem - req_words;
                        words_req <= words_req + req_words;
                    end
                    if (xfer_abort)
                        state <= ST_IDLE;
                    else if (req_ack) begin
                        if (xfer_rem == req_words)
                            state <= ST_FIN;
                        else if (elem_rem == req_words)
                            state <= ST_WAIT_SG;
                        else
                            state <= ST_CALC;
                    end
                end

                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
